// File: rtl/inst_cache_dm.sv
// Direct-mapped read-only instruction cache with a beat-based line refill FSM.
// Define ICACHE_BYTE_SWAP_EN to byte-reverse every returned word (memory holds big-endian words).
module inst_cache_dm #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    input  logic              flush,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0]       req_tag_q, req_tag_d;
    logic [IDX_W-1:0]       req_idx_q, req_idx_d;
    logic [OFF_W-1:0]       req_off_q, req_off_d;
    logic                   flushed_q, flushed_d;

    logic [INST_W-1:0]      data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic                   data_we;
    logic                   tag_we;

    logic [OFF_W-1:0]       lk_off;
    logic [IDX_W-1:0]       lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic                   unused_addr_bits;

    assign lk_off = addr[2 +: OFF_W];
    assign lk_idx = addr[2+OFF_W +: IDX_W];
    assign lk_tag = addr[ADDR_W-1 -: TAG_W];
    // A same-cycle flush wins over the lookup, so it can never hit.
    assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag) && !flush;
    assign unused_addr_bits = ^addr[1:0];

`ifdef ICACHE_BYTE_SWAP_EN
    function automatic logic [INST_W-1:0] byte_swap(input logic [INST_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign inst = byte_swap(inst_q);
`else
    assign inst = inst_q;
`endif

    assign inst_valid = inst_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        inst_d       = '0;
        inst_valid_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cnt_d        = cnt_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_off_d    = req_off_q;
        flushed_d    = flushed_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        if (flush) begin
            valid_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (ce && !stall) begin
                    if (lk_hit) begin
                        inst_d       = data_mem[{lk_idx, lk_off}];
                        inst_valid_d = 1'b1;
                    end else begin
                        state_d    = S_REFILL;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {lk_tag, lk_idx, {(OFF_W+2){1'b0}}};
                        cnt_d      = '0;
                        req_tag_d  = lk_tag;
                        req_idx_d  = lk_idx;
                        req_off_d  = lk_off;
                        flushed_d  = 1'b0;
                    end
                end
            end

            S_REFILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(LINE_WORDS-1)) begin
                        // A flush seen anywhere during the refill keeps the line invalid.
                        tag_we    = 1'b1;
                        mem_req_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_RESP;
                        if (!flush && !flushed_q) begin
                            valid_d[req_idx_q] = 1'b1;
                        end
                    end
                end
            end

            S_RESP: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (!stall) begin
                    inst_d       = data_mem[{req_idx_q, req_off_q}];
                    inst_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_off_q    <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            req_off_q    <= req_off_d;
            flushed_q    <= flushed_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{req_idx_q, cnt_q}] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[req_idx_q] <= req_tag_q;
        end
    end

endmodule
